counter_sequencer: RTL
======================

# counter_sequencer

Run controller for the team's synchronous up-counter datapath. It sequences one counter through start, hold, terminal-count and stop. It supports one-shot or auto-reload operation and an optional clock prescaler. Upstream control logic issues single-cycle commands to it, and the block reports busy, a done pulse and the live count.

## Interface
- `WIDTH`, default 8: counter and limit width.
- `PRESCALE_WIDTH`, default 4: prescale divisor field width.
- `clock` input 1: system clock, rising-edge.
- `reset` input 1: synchronous, active-high.
- `cmd_start` input 1: pulse; latch parameters and (re)start the count.
- `cmd_stop` input 1: pulse; abort and return to IDLE.
- `hold` input 1: level; freeze progress while RUN.
- `load_value` input WIDTH: terminal count, sampled on start.
- `auto_reload` input 1: reload mode, sampled on start.
- `prescale` input PRESCALE_WIDTH: tick every `prescale`+1 cycles, sampled on start.
- `count` output WIDTH: current count, registered.
- `state` output 2: IDLE=00, RUN=01, PAUSED=10, DONE=11.
- `busy` output 1: high when `state` is RUN or PAUSED. Decoded combinationally from `state`.
- `done` output 1: registered, one-cycle pulse per terminal tick.

## Operation
- **Reset:** `state`=IDLE, `count`=0, `done`=0, internal limit/prescaler/mode registers=0.
- **Command priority** (same cycle): `cmd_stop` > `cmd_start` > `hold`.
- **`cmd_stop`, any state:** go to IDLE and clear `count` to 0. The prescaler also clears.
- **`cmd_start`, any state:**
  - Latch `load_value` to limit L, `auto_reload` to mode, `prescale` to P.
  - Clear `count` and the prescaler, then go to RUN.
  - This applies even when RUN, PAUSED or DONE (restart). `hold` in the same cycle is ignored.
- **IDLE:** `count` holds 0. No ticks.
- **RUN:**
  - A tick occurs when the prescaler equals P. The prescaler then clears; otherwise it increments.
  - On a tick with `count` < L: `count` increments by 1.
  - On a tick with `count` == L (terminal): `done` pulses.
    - Reload mode: `count` goes to 0 and `state` stays RUN.
    - One-shot mode: `state` goes to DONE and `count` holds L.
  - If `hold` is sampled high, go to PAUSED. No tick is processed that cycle and the prescaler freezes.
- **PAUSED:** `count` and the prescaler freeze. When `hold` is sampled low, return to RUN; the first tick evaluation happens on the following edge.
- **DONE:** `count` holds L and no ticks occur. Only `cmd_start` or `cmd_stop` leave this state.
- **Arithmetic:** `count` never exceeds L, so it never wraps. L=0 makes every tick terminal. L=2^WIDTH−1 gives 2^WIDTH ticks per period.
- **`hold` outside RUN/PAUSED:** no effect.

## Timing
- `cmd_start` sampled at edge k: `state`=RUN and `count`=0 after edge k.
- With P=0 and no hold:
  - `count`=n after edge k+n, for n ≤ L.
  - Terminal tick at edge k+L+1: `done`=1 during cycle k+L+1 only.
  - One-shot: `state`=DONE after edge k+L+1.
  - Reload: `count`=0 after edge k+L+1; period is L+1 cycles.
- General period: (L+1)·(P+1) cycles between `done` pulses. Each PAUSED cycle, plus one resume cycle per hold episode, extends it.
- `done` changes on the same edge as `count` and `state`.
- Commands have one-cycle latency; there are no combinational paths from inputs to outputs.
- Restart on the terminal edge: start wins and `done` is not pulsed.
- Stop on the terminal edge: stop wins and `done` is not pulsed.

## Configuration
- **`COUNTER_SEQUENCER_PRESCALER_EN` defined:** prescaler register and divider compiled in; behaviour as above.
- **Not defined:**
  - Prescaler logic is removed and P is treated as 0, so a tick occurs every RUN cycle.
  - The `prescale` port remains but is ignored.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-RUN (L=5) → next cycle `state`=00, `count`=0, `done`=0, `busy`=0.
- **One-shot:** L=3, P=0, `auto_reload`=0, start at edge k.
  - `count` goes 0,1,2,3 after edges k..k+3.
  - `done` is high only in cycle k+4, then `state`=11 with `count` holding 3.
  - Stop → `state`=00, `count`=0.
- **Reload with prescale** (macro defined): L=2, P=1 → `count` advances every 2 cycles and `done` pulses every 6 cycles, 4 pulses over 24 cycles. With the macro undefined, the same stimulus gives a pulse every 3 cycles.
- **Hold:** L=4, P=0, `hold` high for 3 cycles at `count`=2.
  - `state`=10 and `count` frozen at 2.
  - After release, `count`=3 two edges later.
  - `done` arrives 4 cycles later than with no hold.
- **Restart and priority:**
  - Start during RUN at `count`=3 with L=7 → `count`=0 and new L latched.
  - Start+stop in the same cycle → IDLE.
  - Start on the terminal edge → no `done` pulse, `count`=0.
- **Boundary:**
  - L=0, reload → `done` high every cycle from cycle k+1 while `count` stays 0.
  - L=255, WIDTH=8 → `done` every 256 cycles and `count` never wraps past 255.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller for a synchronous up-counter.
// Sequences one counter through IDLE / RUN / PAUSED / DONE with one-shot or
// auto-reload operation. The optional clock prescaler is compiled in only when
// COUNTER_SEQUENCER_PRESCALER_EN is defined; otherwise every RUN cycle is a tick
// and the prescale port is ignored.
//
// Command handshake: cmd_start and cmd_stop are single-cycle pulses with no
// ready/ack; each is acted on at the clock edge where it is sampled high, with
// priority cmd_stop > cmd_start > hold. All outputs are registered or decoded
// from registered state, so there is no combinational input-to-output path.
module counter_sequencer #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_start,
  input  logic                      cmd_stop,
  input  logic                      hold,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      auto_reload,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]          count,
  output logic [1:0]                state,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  // Prescaler control produced by the sequencer, consumed by the divider.
  logic             tick;
  logic             psc_clear;
  logic             psc_step;
  logic             do_start;

  assign do_start = cmd_start && !cmd_stop;

  // Next-state, count and done decode; defaults hold everything first.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    psc_clear = 1'b0;
    psc_step  = 1'b0;
    if (cmd_stop) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      psc_clear = 1'b1;
    end else if (cmd_start) begin
      limit_d   = load_value;
      mode_d    = auto_reload;
      count_d   = '0;
      psc_clear = 1'b1;
      state_d   = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_d = '0;
        end
        ST_RUN: begin
          if (hold) begin
            // Pause without evaluating a tick; the prescaler freezes too.
            state_d = ST_PAUSED;
          end else if (tick) begin
            psc_clear = 1'b1;
            if (count_q == limit_q) begin
              done_d = 1'b1;
              if (mode_q) begin
                count_d = '0;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end else begin
            psc_step = 1'b1;
          end
        end
        ST_PAUSED: begin
          // Resume costs one cycle: the first tick is evaluated on the next edge.
          if (!hold) state_d = ST_RUN;
        end
        ST_DONE: begin
          count_d = limit_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTER_SEQUENCER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;

  assign tick = (psc_q == p_q);

  // Divider next-state: clear on command or tick, count up on a non-tick RUN cycle.
  always_comb begin
    psc_d = psc_q;
    p_d   = p_q;
    if (psc_clear) begin
      psc_d = '0;
    end else if (psc_step) begin
      psc_d = psc_q + PRESCALE_WIDTH'(1);
    end
    if (do_start) p_d = prescale;
  end

  // Divider registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      psc_q <= '0;
      p_q   <= '0;
    end else begin
      psc_q <= psc_d;
      p_q   <= p_d;
    end
  end
`else
  // Without the divider every RUN cycle is a tick.
  assign tick = 1'b1;
  logic unused_prescale;
  assign unused_prescale = ^{prescale, psc_clear, psc_step, do_start};
`endif

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done  = done_q;

endmodule
